// File: rtl/decoder_pkg.sv
// Shared types and the reference decode function for the register-file
// write-enable decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_BCAST  = 2'b10,
        MODE_RSVD   = 2'b11
    } dec_mode_t;

    localparam int MAX_AW = 8;
    localparam int MAX_N  = 1 << MAX_AW;

    // Result is MAX_N wide; callers keep the low 2**aw bits.
    function automatic logic [MAX_N-1:0] decode_word(
        input logic [MAX_AW-1:0] addr,
        input logic              enable,
        input dec_mode_t         mode,
        input int                aw,
        input int                zero_reg
    );
        logic [MAX_N-1:0] word;
        int               n;
        int               a;
        n    = 1 << aw;
        a    = int'(addr);
        word = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                case (mode)
                    MODE_ONEHOT: word[i] = (i == a);
                    MODE_THERM:  word[i] = (i <= a);
                    MODE_BCAST:  word[i] = 1'b1;
                    MODE_RSVD:   word[i] = 1'b0;
                    default:     word[i] = 1'b0;
                endcase
            end else begin
                word[i] = 1'b0;
            end
        end
        if (!enable) begin
            word = '0;
        end
        if (zero_reg >= 0 && zero_reg < n) begin
            word[zero_reg] = 1'b0;
        end
        return word;
    endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational N-to-2^N decode of one beat, with reserved-mode error flag.
module decode_core
    import decoder_pkg::*;
#(
    parameter int AW       = 5,
    parameter int ZERO_REG = 31
) (
    input  logic [AW-1:0]      addr,
    input  logic               enable,
    input  logic [1:0]         mode,
    output logic [2**AW-1:0]   dec,
    output logic               err
);

    localparam int N = 2**AW;

    logic [MAX_N-1:0] word_s;
    logic             unused_s;

    assign word_s   = decode_word(MAX_AW'(addr), enable, dec_mode_t'(mode), AW, ZERO_REG);
    assign dec      = word_s[N-1:0];
    assign err      = (mode == 2'b11);
    // Upper bits beyond N are always zero; fold them away.
    assign unused_s = ^word_s;

endmodule

// File: rtl/pipelined_decoder.sv
// Registered decoder with valid/ready handshake: output register plus one skid
// entry, so a stalled consumer never loses or repeats a decode.
module pipelined_decoder
    import decoder_pkg::*;
#(
    parameter int AW       = 5,
    parameter int ZERO_REG = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AW-1:0]      in_addr,
    input  logic               in_enable,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2**AW-1:0]   out_dec,
    output logic               out_err
);

    localparam int N = 2**AW;

    logic [N-1:0] dec_s;
    logic         err_s;
    logic         accept_s;
    logic         main_free_s;

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_dec_q,   out_dec_d;
    logic         out_err_q,   out_err_d;
    logic         skid_valid_q, skid_valid_d;
    logic [N-1:0] skid_dec_q,  skid_dec_d;
    logic         skid_err_q,  skid_err_d;
    logic         in_ready_q,  in_ready_d;

    decode_core #(.AW(AW), .ZERO_REG(ZERO_REG)) u_core (
        .addr   (in_addr),
        .enable (in_enable),
        .mode   (in_mode),
        .dec    (dec_s),
        .err    (err_s)
    );

    // Next-state for the main/skid pair; skid always drains before new input.
    always_comb begin
        accept_s     = in_valid && in_ready_q;
        main_free_s  = !out_valid_q || out_ready;
        out_valid_d  = out_valid_q;
        out_dec_d    = out_dec_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_dec_d   = skid_dec_q;
        skid_err_d   = skid_err_q;
        if (main_free_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_dec_d    = skid_dec_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d  = 1'b1;
                out_dec_d    = dec_s;
                out_err_d    = err_s;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_dec_d   = dec_s;
            skid_err_d   = err_s;
        end else begin
            skid_valid_d = skid_valid_q;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; in_ready is held low throughout reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_dec_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_dec_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_dec_q    <= out_dec_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_dec_q   <= skid_dec_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_dec   = out_dec_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Bench for pipelined_decoder: two instances (AW=2 unmasked, AW=5 masked) on
// shared stimulus, each checked every cycle against a FIFO reference model.
module tb_pipelined_decoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_addr;
    logic        in_enable;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        ir [2];
    logic        ov [2];
    logic        oe [2];
    logic [31:0] od [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int inst, input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h, expected %h at %0t", inst, nm, act, exp, $time);
        end
    endtask

    // Word the decoder must produce, computed with shifts and masks.
    function automatic logic [31:0] model_word(input int a, input bit e, input int m, input int aw, input int zr);
        longint unsigned n;
        longint unsigned full;
        longint unsigned w;
        int              aa;
        n    = 64'd1 << aw;
        full = (64'd1 << n) - 64'd1;
        aa   = a % int'(n);
        case (m)
            0:       w = 64'd1 << aa;
            1:       w = (64'd2 << aa) - 64'd1;
            2:       w = full;
            default: w = 64'd0;
        endcase
        if (!e) w = 64'd0;
        if (zr < int'(n)) w = w & ~(64'd1 << zr);
        return 32'(w & full);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int AWG = (g == 0) ? 2 : 5;
        localparam int ZRG = (g == 0) ? 4 : 31;
        localparam int NG  = 1 << AWG;

        logic [NG-1:0] dec_s;
        logic          ir_s, ov_s, oe_s;
        logic [32:0]   exp_q [$];
        logic          rst_last  = 1'b1;
        logic          held      = 1'b0;
        logic [32:0]   held_word = 33'd0;

        pipelined_decoder #(.AW(AWG), .ZERO_REG(ZRG)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (ir_s),
            .in_addr   (in_addr[AWG-1:0]),
            .in_enable (in_enable),
            .in_mode   (in_mode),
            .out_valid (ov_s),
            .out_ready (out_ready),
            .out_dec   (dec_s),
            .out_err   (oe_s)
        );

        assign ir[g] = ir_s;
        assign ov[g] = ov_s;
        assign oe[g] = oe_s;
        assign od[g] = 32'(dec_s);

        // Compare outputs with the model, then advance it by the coming edge.
        always @(negedge clk) begin
            logic [32:0] act;
            bit          can_in;
            act = {oe_s, 32'(dec_s)};
            if (rst_last) begin
                chk(g, "reset_out_valid", 33'(ov_s), 33'd0);
                chk(g, "reset_in_ready", 33'(ir_s), 33'd0);
            end else begin
                chk(g, "out_valid", 33'(ov_s), 33'(exp_q.size() > 0));
                chk(g, "in_ready", 33'(ir_s), 33'(exp_q.size() < 2));
                if (exp_q.size() > 0) chk(g, "out_word", act, exp_q[0]);
                if (held) chk(g, "stall_stable", act, held_word);
            end
            held      = !reset && !rst_last && ov_s && !out_ready;
            held_word = act;
            if (reset) begin
                exp_q.delete();
            end else begin
                can_in = !rst_last && (exp_q.size() < 2);
                if (!rst_last && exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                if (in_valid && can_in)
                    exp_q.push_back({in_mode == 2'b11,
                                     model_word(int'(in_addr), in_enable, int'(in_mode), AWG, ZRG)});
            end
            rst_last = reset;
        end
    end

    task automatic beat(input int a, input bit e, input int m);
        in_valid  = 1'b1;
        in_addr   = 5'(a);
        in_enable = e;
        in_mode   = 2'(m);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] oh_tab [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_addr   = 5'd0;
        in_enable = 1'b0;
        in_mode   = 2'd0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk(0, "rst_out_valid", 33'(ov[0]), 33'd0);
        chk(0, "rst_out_dec", 33'(od[0]), 33'd0);
        chk(1, "rst_out_err", 33'(oe[1]), 33'd0);
        chk(0, "rst_in_ready", 33'(ir[0]), 33'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk(0, "in_ready_after_reset", 33'(ir[0]), 33'd1);

        for (int a = 0; a < 4; a++) begin
            beat(a, 1'b1, 0);
            chk(0, "onehot_sweep", 33'(od[0]), 33'(oh_tab[a]));
            chk(0, "onehot_valid", 33'(ov[0]), 33'd1);
        end
        for (int a = 0; a < 4; a++) begin
            beat(a, 1'b0, 0);
            chk(0, "disabled_sweep", 33'(od[0]), 33'd0);
        end

        beat(31, 1'b1, 0);
        chk(1, "onehot_zero_reg", 33'(od[1]), 33'd0);
        beat(3, 1'b1, 1);
        chk(1, "therm_3", 33'(od[1]), 33'h0_0000_000F);
        beat(31, 1'b1, 1);
        chk(1, "therm_31", 33'(od[1]), 33'h0_7FFF_FFFF);
        beat(0, 1'b1, 2);
        chk(1, "bcast_masked", 33'(od[1]), 33'h0_7FFF_FFFF);
        chk(0, "bcast_unmasked", 33'(od[0]), 33'h0_0000_000F);
        beat(7, 1'b1, 3);
        chk(1, "rsvd_dec", 33'(od[1]), 33'd0);
        chk(1, "rsvd_err", 33'(oe[1]), 33'd1);
        beat(0, 1'b1, 0);
        chk(1, "err_not_sticky", 33'(oe[1]), 33'd0);
        chk(1, "onehot_0", 33'(od[1]), 33'd1);
        idle(3);

        // Stall: A held in main, B in skid, then both drain in order.
        out_ready = 1'b0;
        beat(1, 1'b1, 0);
        chk(0, "stall_a_out", 33'(od[0]), 33'h2);
        chk(0, "stall_ready_a", 33'(ir[0]), 33'd1);
        beat(2, 1'b1, 0);
        chk(0, "stall_a_held", 33'(od[0]), 33'h2);
        chk(0, "stall_skid_full", 33'(ir[0]), 33'd0);
        idle(1);
        chk(0, "stall_a_still", 33'(od[0]), 33'h2);
        out_ready = 1'b1;
        idle(1);
        chk(0, "drain_b_out", 33'(od[0]), 33'h4);
        chk(0, "drain_b_valid", 33'(ov[0]), 33'd1);
        chk(0, "drain_ready_back", 33'(ir[0]), 33'd1);
        idle(1);
        chk(0, "drain_empty", 33'(ov[0]), 33'd0);

        for (int c = 0; c < 2000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_addr   = 5'($urandom_range(0, 31));
            in_enable = ($urandom_range(0, 7) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(3);

        // Reset with both entries occupied discards them.
        out_ready = 1'b0;
        beat(1, 1'b1, 0);
        beat(2, 1'b1, 0);
        chk(0, "full_before_reset", 33'(ir[0]), 33'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk(0, "mid_reset_valid", 33'(ov[0]), 33'd0);
        chk(0, "mid_reset_dec", 33'(od[0]), 33'd0);
        chk(1, "mid_reset_dec", 33'(od[1]), 33'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk(0, "no_ghost_beat", 33'(ov[0]), 33'd0);
            chk(1, "no_ghost_beat", 33'(ov[1]), 33'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
